// File: rtl/spi_xfer_queue.sv
`default_nettype none
// ============================================================================
// Module      : spi_xfer_queue
// Description : Byte queue between a host stream interface and an SPI master.
//               Host bytes enter a TX FIFO, are launched one at a time to the
//               SPI master, and the received bytes are returned through an RX
//               FIFO. A per-transfer watchdog aborts transfers that never
//               complete and raises a sticky timeout flag.
//               Optional feature macro: SPI_XFER_QUEUE_CNT_EN adds a 16-bit
//               completed-transfer counter (xfer_cnt) with clear (cnt_clr).
// Revision    : 1.0 - initial release
// ============================================================================
module spi_xfer_queue #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [7:0]                 in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [7:0]                 out_data,
  input  logic                       out_ready,
  output logic                       spi_start,
  output logic [7:0]                 spi_tx_data,
  input  logic                       spi_busy,
  input  logic                       spi_done,
  input  logic [7:0]                 spi_rx_data,
  output logic [$clog2(DEPTH):0]     tx_level,
  output logic [$clog2(DEPTH):0]     rx_level,
  output logic                       idle,
  output logic                       timeout_err,
  input  logic                       err_clr
`ifdef SPI_XFER_QUEUE_CNT_EN
  ,
  output logic [15:0]                xfer_cnt,
  input  logic                       cnt_clr
`endif
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_LW = c_AW + 1;
  localparam int c_TW = $clog2(TIMEOUT + 1);

  localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);
  localparam logic [c_LW-1:0] c_LVL_ONE = c_LW'(1);
  localparam logic [c_LW-1:0] c_FULL    = c_LW'(DEPTH);
  localparam logic [c_TW-1:0] c_TMO_LST = c_TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [7:0]      r_tx_mem [DEPTH];
  logic [c_AW-1:0] r_tx_wr;
  logic [c_AW-1:0] r_tx_rd;
  logic [c_LW-1:0] r_tx_lvl;

  logic [7:0]      r_rx_mem [DEPTH];
  logic [c_AW-1:0] r_rx_wr;
  logic [c_AW-1:0] r_rx_rd;
  logic [c_LW-1:0] r_rx_lvl;

  logic [c_TW-1:0] r_wait_cnt;
  logic [7:0]      r_spi_tx_data;
  logic            r_timeout_err;

  logic w_tx_push;
  logic w_tx_pop;
  logic w_rx_push;
  logic w_rx_pop;
  logic w_can_go;
  logic w_tmo;

  // A launch needs a queued byte, a free RX slot reserved for its reply,
  // and an SPI master that is not busy.
  assign w_can_go  = (r_tx_lvl != '0) && (r_rx_lvl != c_FULL) && !spi_busy;
  assign w_tx_push = in_valid && in_ready;
  assign w_tx_pop  = (r_state == LAUNCH);
  assign w_rx_push = (r_state == WAIT_DONE) && spi_done;
  assign w_rx_pop  = out_valid && out_ready;
  assign w_tmo     = (r_state == WAIT_DONE) && !spi_done && (r_wait_cnt == c_TMO_LST);

  assign in_ready    = (r_tx_lvl != c_FULL);
  assign out_valid   = (r_rx_lvl != '0);
  assign out_data    = r_rx_mem[r_rx_rd];
  assign spi_tx_data = r_spi_tx_data;
  assign tx_level    = r_tx_lvl;
  assign rx_level    = r_rx_lvl;
  assign idle        = (r_state == IDLE) && (r_tx_lvl == '0);
  assign timeout_err = r_timeout_err;

  // TX storage: written on host push, no reset needed for data.
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr] <= in_data;
  end

  // TX pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_wr  <= '0;
      r_tx_rd  <= '0;
      r_tx_lvl <= '0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + c_PTR_ONE;
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + c_PTR_ONE;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_lvl <= r_tx_lvl + c_LVL_ONE;
        2'b01:   r_tx_lvl <= r_tx_lvl - c_LVL_ONE;
        default: r_tx_lvl <= r_tx_lvl;
      endcase
    end
  end

  // RX storage: written with the SPI reply byte on completion.
  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wr] <= spi_rx_data;
  end

  // RX pointers and occupancy; a same-cycle push and pop leave level unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_wr  <= '0;
      r_rx_rd  <= '0;
      r_rx_lvl <= '0;
    end else begin
      if (w_rx_push) r_rx_wr <= r_rx_wr + c_PTR_ONE;
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + c_PTR_ONE;
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_lvl <= r_rx_lvl + c_LVL_ONE;
        2'b01:   r_rx_lvl <= r_rx_lvl - c_LVL_ONE;
        default: r_rx_lvl <= r_rx_lvl;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state and launch strobe.
  always_comb begin
    w_state_nxt = r_state;
    spi_start   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_can_go) w_state_nxt = LAUNCH;
      end
      LAUNCH: begin
        spi_start   = 1'b1;
        w_state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (spi_done || w_tmo) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Capture the TX head as LAUNCH is entered so it is valid with spi_start
  // and held until the next launch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_spi_tx_data <= 8'h00;
    else if ((r_state == IDLE) && w_can_go) r_spi_tx_data <= r_tx_mem[r_tx_rd];
  end

  // Watchdog: counts cycles spent in WAIT_DONE, restarts on every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_wait_cnt <= '0;
    else if (r_state != WAIT_DONE) r_wait_cnt <= '0;
    else                           r_wait_cnt <= r_wait_cnt + c_TW'(1);
  end

  // Sticky timeout flag; a new timeout takes priority over a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_timeout_err <= 1'b0;
    else if (w_tmo)   r_timeout_err <= 1'b1;
    else if (err_clr) r_timeout_err <= 1'b0;
  end

`ifdef SPI_XFER_QUEUE_CNT_EN
  logic [15:0] r_xfer_cnt;

  assign xfer_cnt = r_xfer_cnt;

  // Completed-transfer counter; clear takes priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_xfer_cnt <= 16'h0000;
    else if (cnt_clr)   r_xfer_cnt <= 16'h0000;
    else if (w_rx_push) r_xfer_cnt <= r_xfer_cnt + 16'h0001;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_xfer_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_xfer_queue
// Description : Self-checking bench for spi_xfer_queue. A behavioural SPI
//               slave model answers launches; byte queues predict the order
//               of launched and returned bytes. A second instance with a
//               short watchdog covers the timeout path.
//               Optional feature macro: SPI_XFER_QUEUE_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_xfer_queue;

  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          out_valid;
  logic [7:0]    out_data;
  logic          out_ready;
  logic          spi_start;
  logic [7:0]    spi_tx_data;
  logic          spi_busy;
  logic          spi_done;
  logic [7:0]    spi_rx_data;
  logic [LW-1:0] tx_level;
  logic [LW-1:0] rx_level;
  logic          idle;
  logic          timeout_err;
  logic          err_clr;
`ifdef SPI_XFER_QUEUE_CNT_EN
  logic [15:0]   xfer_cnt;
  logic          cnt_clr;
`endif

  // SPI slave model drive and manual overrides
  logic       resp_busy, resp_done, hold_busy, man_done;
  logic [7:0] resp_rx, man_rx;
  assign spi_busy    = resp_busy | hold_busy;
  assign spi_done    = resp_done | man_done;
  assign spi_rx_data = man_done ? man_rx : resp_rx;

  // Short-watchdog instance signals
  logic          t_in_valid;
  logic [7:0]    t_in_data;
  logic          t_in_ready;
  logic          t_out_valid;
  logic [7:0]    t_out_data;
  logic          t_out_ready;
  logic          t_spi_start;
  logic [7:0]    t_spi_tx_data;
  logic          t_spi_busy;
  logic          t_spi_done;
  logic [7:0]    t_spi_rx_data;
  logic [LW-1:0] t_tx_level;
  logic [LW-1:0] t_rx_level;
  logic          t_idle;
  logic          t_timeout_err;
  logic          t_err_clr;
`ifdef SPI_XFER_QUEUE_CNT_EN
  logic [15:0]   t_xfer_cnt;
  logic          t_cnt_clr;
`endif

  spi_xfer_queue #(.DEPTH(DEPTH), .TIMEOUT(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .spi_start(spi_start), .spi_tx_data(spi_tx_data), .spi_busy(spi_busy),
    .spi_done(spi_done), .spi_rx_data(spi_rx_data),
    .tx_level(tx_level), .rx_level(rx_level), .idle(idle),
    .timeout_err(timeout_err), .err_clr(err_clr)
`ifdef SPI_XFER_QUEUE_CNT_EN
    , .xfer_cnt(xfer_cnt), .cnt_clr(cnt_clr)
`endif
  );

  spi_xfer_queue #(.DEPTH(DEPTH), .TIMEOUT(16)) dut_t (
    .clk(clk), .rst_n(rst_n),
    .in_valid(t_in_valid), .in_data(t_in_data), .in_ready(t_in_ready),
    .out_valid(t_out_valid), .out_data(t_out_data), .out_ready(t_out_ready),
    .spi_start(t_spi_start), .spi_tx_data(t_spi_tx_data), .spi_busy(t_spi_busy),
    .spi_done(t_spi_done), .spi_rx_data(t_spi_rx_data),
    .tx_level(t_tx_level), .rx_level(t_rx_level), .idle(t_idle),
    .timeout_err(t_timeout_err), .err_clr(t_err_clr)
`ifdef SPI_XFER_QUEUE_CNT_EN
    , .xfer_cnt(t_xfer_cnt), .cnt_clr(t_cnt_clr)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];
  int         start_cnt = 0;
  logic       resp_en;
  int         dmin, dmax;
  logic       fixed_rx_en;
  logic [7:0] fixed_rx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // SPI slave model: every launch must carry the oldest unsent host byte;
  // when enabled, it answers after a random delay with a random reply.
  initial begin
    int d;
    resp_busy = 1'b0;
    resp_done = 1'b0;
    resp_rx   = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n && spi_start) begin
        start_cnt = start_cnt + 1;
        chk("launch_expected", 32'(exp_tx.size() != 0), 32'd1);
        if (exp_tx.size() != 0) chk("spi_tx_data", 32'(spi_tx_data), 32'(exp_tx.pop_front()));
        if (resp_en) begin
          resp_busy = 1'b1;
          d = $urandom_range(dmax, dmin);
          repeat (d) @(negedge clk);
          resp_rx   = fixed_rx_en ? fixed_rx : 8'($urandom);
          resp_done = 1'b1;
          exp_rx.push_back(resp_rx);
          @(negedge clk);
          resp_done = 1'b0;
          resp_busy = 1'b0;
        end
      end
    end
  end

  // Host push: hold in_valid until accepted or the bound expires.
  task automatic push_byte(input logic [7:0] b, input int bound);
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < bound; i++) begin
      if (in_ready) begin
        exp_tx.push_back(b);
        @(negedge clk);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("push_accept", 32'(in_ready), 32'd1);
  endtask

  // Host pop: wait for out_valid, compare head against prediction, accept it.
  task automatic pop_byte(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (out_valid) begin
        chk("rx_avail", 32'(exp_rx.size() != 0), 32'd1);
        if (exp_rx.size() != 0) chk("rx_data", 32'(out_data), 32'(exp_rx.pop_front()));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        return;
      end
      @(negedge clk);
    end
    chk("pop_wait", 32'(out_valid), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, n, pushed, popped;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; err_clr = 1'b0;
    hold_busy = 1'b0; man_done = 1'b0; man_rx = 8'h00;
    resp_en = 1'b1; dmin = 1; dmax = 1; fixed_rx_en = 1'b0; fixed_rx = 8'h00;
    t_in_valid = 1'b0; t_in_data = 8'h00; t_out_ready = 1'b0; t_spi_busy = 1'b0;
    t_spi_done = 1'b0; t_spi_rx_data = 8'h00; t_err_clr = 1'b0;
`ifdef SPI_XFER_QUEUE_CNT_EN
    cnt_clr = 1'b0; t_cnt_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_in_ready",  32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_idle",      32'(idle), 32'd1);
    chk("rst_spi_start", 32'(spi_start), 32'd0);
    chk("rst_tx_data",   32'(spi_tx_data), 32'h00);
    chk("rst_tx_level",  32'(tx_level), 32'd0);
    chk("rst_rx_level",  32'(rx_level), 32'd0);
    chk("rst_tmo_err",   32'(timeout_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single transfer with 20-cycle reply
    dmin = 20; dmax = 20; fixed_rx_en = 1'b1; fixed_rx = 8'h3C;
    s0 = start_cnt;
    push_byte(8'hA5, 5);
    n = 0;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    chk("single_out_valid", 32'(out_valid), 32'd1);
    chk("single_out_data",  32'(out_data), 32'h3C);
    chk("single_starts",    32'(start_cnt - s0), 32'd1);
    chk("single_idle",      32'(idle), 32'd1);
    pop_byte(5);
    chk("single_rx_level",  32'(rx_level), 32'd0);
    fixed_rx_en = 1'b0;

    // Back-to-back launches with the fastest reply: spacing of 3 cycles
    dmin = 1; dmax = 1;
    hold_busy = 1'b1;
    push_byte(8'h01, 5);
    push_byte(8'h02, 5);
    hold_busy = 1'b0;
    n = 0;
    while (!spi_start && n < 20) begin @(negedge clk); n++; end
    chk("b2b_first_start", 32'(spi_start), 32'd1);
    n = 0;
    do begin @(negedge clk); n++; end while (!spi_start && n < 20);
    chk("b2b_spacing", 32'(n), 32'd3);
    pop_byte(20);
    pop_byte(20);

    // Fill TX while the SPI master is busy, RX never drained
    dmin = 1; dmax = 6;
    hold_busy = 1'b1;
    s0 = start_cnt;
    for (int i = 0; i < DEPTH; i++) push_byte(8'($urandom), 5);
    chk("full_tx_level", 32'(tx_level), 32'd8);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_idle",     32'(idle), 32'd0);
    in_valid = 1'b1; in_data = 8'($urandom);
    repeat (3) @(negedge clk);
    chk("full_hold_level", 32'(tx_level), 32'd8);
    hold_busy = 1'b0;
    push_byte(in_data, 20);
    chk("ninth_after_launch", 32'(start_cnt - s0), 32'd1);
    repeat (300) @(negedge clk);
    chk("rxfull_rx_level",  32'(rx_level), 32'd8);
    chk("rxfull_tx_level",  32'(tx_level), 32'd1);
    chk("rxfull_starts",    32'(start_cnt - s0), 32'd8);
    chk("rxfull_out_valid", 32'(out_valid), 32'd1);
    pop_byte(5);
    n = 0;
    while ((start_cnt - s0) < 9 && n < 50) begin @(negedge clk); n++; end
    chk("rxfull_ninth_start", 32'(start_cnt - s0), 32'd9);
    for (int i = 0; i < DEPTH; i++) pop_byte(100);
    repeat (2) @(negedge clk);
    chk("drain_idle",     32'(idle), 32'd1);
    chk("drain_rx_level", 32'(rx_level), 32'd0);

    // Random traffic: random host pacing, random reply delays and data
    dmin = 1; dmax = 8;
    pushed = 0; popped = 0;
    for (int cyc = 0; cyc < 4000 && popped < 24; cyc++) begin
      in_valid  = (pushed < 24) && ($urandom_range(9, 0) < 7);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(1, 0) == 1);
      if (in_valid && in_ready) begin exp_tx.push_back(in_data); pushed++; end
      if (out_valid && out_ready) begin
        chk("rand_rx_avail", 32'(exp_rx.size() != 0), 32'd1);
        if (exp_rx.size() != 0) chk("rand_rx_data", 32'(out_data), 32'(exp_rx.pop_front()));
        popped++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("rand_popped", 32'(popped), 32'd24);
    repeat (2) @(negedge clk);
    chk("rand_idle", 32'(idle), 32'd1);

    // Watchdog path on the short-timeout instance
    t_in_valid = 1'b1; t_in_data = 8'h11;
    @(negedge clk);
    t_in_data = 8'h22;
    @(negedge clk);
    t_in_valid = 1'b0;
    n = 0;
    while (!t_spi_start && n < 20) begin @(negedge clk); n++; end
    chk("tmo_first_start", 32'(t_spi_start), 32'd1);
    chk("tmo_first_data",  32'(t_spi_tx_data), 32'h11);
    n = 0;
    while (!t_timeout_err && n < 40) begin @(negedge clk); n++; end
    chk("tmo_cycles",    32'(n), 32'd17);
    chk("tmo_rx_level",  32'(t_rx_level), 32'd0);
    @(negedge clk);
    chk("tmo_next_start", 32'(t_spi_start), 32'd1);
    chk("tmo_next_data",  32'(t_spi_tx_data), 32'h22);
    t_err_clr = 1'b1;
    @(negedge clk);
    chk("tmo_clr", 32'(t_timeout_err), 32'd0);
    n = 1;
    while (!t_timeout_err && n < 40) begin @(negedge clk); n++; end
    chk("tmo_set_wins", 32'(n), 32'd17);
    t_err_clr = 1'b0;
    @(negedge clk);
    chk("tmo_sticky", 32'(t_timeout_err), 32'd1);
    t_err_clr = 1'b1;
    @(negedge clk);
    t_err_clr = 1'b0;
    chk("tmo_clr2", 32'(t_timeout_err), 32'd0);

    // Reset during WAIT_DONE, then a late completion pulse
    resp_en = 1'b0;
    push_byte(8'h77, 5);
    n = 0;
    while (!spi_start && n < 20) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    exp_tx.delete();
    exp_rx.delete();
    @(negedge clk);
    chk("midrst_tx_level", 32'(tx_level), 32'd0);
    chk("midrst_idle",     32'(idle), 32'd1);
    chk("midrst_tx_data",  32'(spi_tx_data), 32'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    s0 = start_cnt;
    man_rx = 8'hEE; man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    repeat (4) @(negedge clk);
    chk("late_done_rx_level", 32'(rx_level), 32'd0);
    chk("late_done_out_valid", 32'(out_valid), 32'd0);
    chk("late_done_starts",   32'(start_cnt - s0), 32'd0);
    resp_en = 1'b1;

`ifdef SPI_XFER_QUEUE_CNT_EN
    // Transfer counter
    dmin = 1; dmax = 4;
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("cnt_cleared", 32'(xfer_cnt), 32'd0);
    for (int i = 0; i < 3; i++) push_byte(8'($urandom), 10);
    for (int i = 0; i < 3; i++) pop_byte(100);
    chk("cnt_three", 32'(xfer_cnt), 32'd3);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("cnt_clr", 32'(xfer_cnt), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_xfer_queue.md
SPI_XFER_QUEUE -- requirements
Module: spi_xfer_queue

Interface
REQ-001 Parameters SHALL be, one per line:
- DEPTH, 8, entries in each of TX and RX FIFO; power of 2, >=2
- TIMEOUT, 1024, max cycles from spi_start to spi_done before abort
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  host TX byte valid
- in_data  in  8  host TX byte
- in_ready  out  1  TX FIFO not full
- out_valid  out  1  RX FIFO not empty
- out_data  out  8  RX FIFO head byte
- out_ready  in  1  host accepts RX byte
- spi_start  out  1  one-cycle launch pulse to SPI master
- spi_tx_data  out  8  byte for SPI master
- spi_busy  in  1  SPI master busy
- spi_done  in  1  SPI master one-cycle completion pulse
- spi_rx_data  in  8  byte received by SPI master, valid with spi_done
- tx_level  out  $clog2(DEPTH)+1  TX FIFO occupancy
- rx_level  out  $clog2(DEPTH)+1  RX FIFO occupancy
- idle  out  1  TX FIFO empty and FSM in IDLE
- timeout_err  out  1  sticky timeout flag
- err_clr  in  1  clears timeout_err
REQ-003 Clock SHALL be clk; reset SHALL be rst_n, asynchronous, active-low.

Function
REQ-004 TX push SHALL occur on in_valid && in_ready; in_ready SHALL be !tx_full, independent of same-cycle pops.
REQ-005 RX pop SHALL occur on out_valid && out_ready; out_data SHALL be the head, stable while out_valid && !out_ready.
REQ-006 FIFO pointers SHALL be $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0; levels range 0..DEPTH.
REQ-007 FSM states SHALL be IDLE, LAUNCH, WAIT_DONE.
REQ-008 IDLE -> LAUNCH SHALL occur when tx_level!=0 and rx_level<DEPTH and !spi_busy.
REQ-009 In LAUNCH (exactly one cycle) spi_start SHALL be 1, spi_tx_data SHALL be registered from the TX head, TX SHALL pop; next state WAIT_DONE.
REQ-010 spi_tx_data SHALL hold its value until the next LAUNCH.
REQ-011 In WAIT_DONE, on spi_done, spi_rx_data SHALL be pushed to RX in that cycle; next state IDLE.
REQ-012 RX push in REQ-011 SHALL never overflow: one slot is reserved by REQ-008; a same-cycle host pop SHALL still be honoured.
REQ-013 WAIT_DONE SHALL count cycles; at count==TIMEOUT without spi_done, timeout_err SHALL set, no RX push, next state IDLE.
REQ-014 spi_done outside WAIT_DONE SHALL be ignored.
REQ-015 err_clr SHALL clear timeout_err; a same-cycle set SHALL win.
REQ-016 Back-to-back: minimum spacing between spi_start pulses SHALL be 3 cycles (LAUNCH, WAIT_DONE with done, IDLE).

Reset
REQ-017 While rst_n=0: FSM=IDLE, FIFOs empty, spi_start=0, spi_tx_data=0x00, out_valid=0, timeout_err=0, levels=0, idle=1, in_ready=1.
REQ-018 Reset mid-transfer SHALL discard queued and in-flight bytes; late spi_done after reset SHALL be ignored.

Configuration
REQ-019 With SPI_XFER_QUEUE_CNT_EN defined, ports xfer_cnt (out, 16) and cnt_clr (in, 1) SHALL exist; xfer_cnt increments per REQ-011 push, wraps 0xFFFF->0, resets to 0, cnt_clr zeroes it (increment in same cycle loses).
REQ-020 Without SPI_XFER_QUEUE_CNT_EN, those ports and the counter SHALL be absent; all other behaviour identical.

Verification
REQ-021 Push 0xA5, SPI model returns 0x3C after 20 cycles -> one spi_start with spi_tx_data=0xA5, out_data=0x3C, idle=1 after.
REQ-022 Push 8 bytes with in_valid held -> in_ready=0 when tx_level=8; 9th byte accepted only after first LAUNCH.
REQ-023 out_ready=0, 9 bytes queued -> 8 transfers complete, rx_level=8, no 9th spi_start until one RX pop.
REQ-024 TIMEOUT=16, spi_done never asserted -> timeout_err=1 at cycle 16 of WAIT_DONE, rx_level unchanged, next byte launched; err_clr -> 0.
REQ-025 rst_n low during WAIT_DONE, spi_done 2 cycles after release -> no RX push, levels 0, spi_start stays 0.
REQ-026 With SPI_XFER_QUEUE_CNT_EN, 3 transfers -> xfer_cnt=3; cnt_clr -> 0.
